// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared fetch constants and types
package pd_pkg;
   localparam logic [31:0] PC_RESET = 32'h0100_0000;
   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] insn_t;

   typedef struct packed {
      addr_t pc;
      insn_t insn;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - imem request/response, redirect and decode handshake bundle
interface fetch_stage_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [AWIDTH-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [DWIDTH-1:0] imem_rsp_data;
   logic              redirect_valid;
   logic [AWIDTH-1:0] redirect_pc;
   logic              f_valid;
   logic              f_ready;
   logic [AWIDTH-1:0] f_pc;
   logic [DWIDTH-1:0] f_insn;

   modport master (
      output imem_req_valid, imem_req_addr, f_valid, f_pc, f_insn,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc, f_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, f_valid, f_pc, f_insn,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc, f_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, count, full/empty
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = store[rd_ptr];

   // pointer and occupancy bookkeeping; flush discards everything queued
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // payload storage is not reset; it is only read while count is non-zero
   always_ff @(posedge clock) begin
      if (do_push && !flush) store[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch front end (PC, imem requests, decode handshake); FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
   parameter int                AWIDTH   = 32,
   parameter int                DWIDTH   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [AWIDTH-1:0] PC_RESET = AWIDTH'(pd_pkg::PC_RESET)
) (
   input  logic          clock,
   input  logic          reset,
   fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_stall,
   output logic [31:0]   perf_flush
`endif
);
   import pd_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = CW + 2;

   logic [AWIDTH-1:0]        pc;
   logic [CW-1:0]            drop;
   logic [CW-1:0]            tag_count;
   logic [CW-1:0]            buf_count;
   logic [AWIDTH-1:0]        tag_head;
   logic [AWIDTH+DWIDTH-1:0] buf_head;
   logic                     tag_full;
   logic                     tag_empty;
   logic                     buf_full;
   logic                     buf_empty;
   logic [TW-1:0]            inflight_total;
   logic                     req_fire;
   logic                     rsp_take;
   logic                     rsp_drop;
   logic                     f_fire;
   logic                     unused_ok;

   // Every slot is charged: live requests, requests whose data will be thrown
   // away, and instructions parked for decode. This bounds the tag queue and
   // guarantees the output buffer always has room for an accepted response.
   assign inflight_total = TW'(tag_count) + TW'(drop) + TW'(buf_count);

   assign bus.imem_req_valid = !reset && !bus.redirect_valid && (inflight_total < TW'(DEPTH));
   assign bus.imem_req_addr  = pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

   assign rsp_drop = bus.imem_rsp_valid && (drop != '0);
   assign rsp_take = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;

   assign bus.f_valid = !reset && !buf_empty;
   assign f_fire      = bus.f_valid && bus.f_ready;
   assign bus.f_pc    = bus.f_valid ? buf_head[AWIDTH+DWIDTH-1:DWIDTH] : '0;
   assign bus.f_insn  = bus.f_valid ? buf_head[DWIDTH-1:0] : '0;

   assign unused_ok = &{1'b0, tag_full, tag_empty, buf_full, bus.redirect_pc[1:0]};

   fetch_fifo #(
      .WIDTH (AWIDTH),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clock     (clock),
      .reset     (reset),
      .push      (req_fire),
      .push_data (pc),
      .pop       (rsp_take),
      .flush     (bus.redirect_valid),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   fetch_fifo #(
      .WIDTH (AWIDTH + DWIDTH),
      .DEPTH (DEPTH)
   ) u_out_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (rsp_take),
      .push_data ({tag_head, bus.imem_rsp_data}),
      .pop       (f_fire),
      .flush     (bus.redirect_valid),
      .head      (buf_head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // program counter: redirect target (word aligned) wins over sequential advance
   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= PC_RESET;
      end else if (bus.redirect_valid) begin
         pc <= {bus.redirect_pc[AWIDTH-1:2], 2'b00};
      end else if (req_fire) begin
         pc <= pc + AWIDTH'(4);
      end
   end

   // stale-response counter: a redirect converts all live requests into drops,
   // less the one response (if any) that lands in the redirect cycle itself
   always_ff @(posedge clock) begin
      if (reset) begin
         drop <= '0;
      end else if (bus.redirect_valid) begin
         drop <= drop + tag_count - CW'(bus.imem_rsp_valid);
      end else if (rsp_drop) begin
         drop <= drop - CW'(1);
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // saturating event counters for fetched instructions, stalls and flushes
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
         perf_flush   <= '0;
      end else begin
         if (f_fire && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
         if (bus.imem_req_valid && !bus.imem_req_ready && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
         if (bus.redirect_valid && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
`timescale 1ns/1ps
module tb_fetch_stage;
   import pd_pkg::*;

   localparam int DEPTH = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fetch_stage_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

   fetch_stage #(
      .AWIDTH   (32),
      .DWIDTH   (32),
      .DEPTH    (DEPTH),
      .PC_RESET (PC_RESET)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush)
`endif
   );

   typedef struct {
      addr_t addr;
      int    due;
   } mem_req_t;

   typedef struct {
      bit          f_ready;
      bit          exp_req_v;
      logic [31:0] exp_req_addr;
      bit          exp_fv;
      logic [31:0] exp_fpc;
   } vec_t;

   mem_req_t mem_q[$];
   vec_t     tbl[7];
   int       cyc = 0;
   int       lat = 1;
   int       checks = 0;
   int       errors = 0;
   int       accepted, hs_count;
   addr_t    exp_pc, first_pc, hold_pc, hold_addr;
   bit       saw_zero, hold_f, hold_req;
   int       m_fetched, m_stall, m_flush;

   logic  s_reset, s_req_v, s_req_rdy, s_rsp_v, s_fv, s_fr, s_rv;
   addr_t s_addr, s_fpc, s_rpc;
   insn_t s_insn;

   function automatic insn_t mem_word(input addr_t a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock: sample at negedge, score, then advance memory model after posedge
   task automatic step();
      mem_req_t m;
      @(negedge clock);
      s_reset = reset;
      s_req_v = bus.imem_req_valid; s_req_rdy = bus.imem_req_ready; s_addr = bus.imem_req_addr;
      s_rsp_v = bus.imem_rsp_valid;
      s_fv = bus.f_valid; s_fr = bus.f_ready; s_fpc = bus.f_pc; s_insn = bus.f_insn;
      s_rv = bus.redirect_valid; s_rpc = bus.redirect_pc;
      if (!s_reset) begin
         if (hold_f) begin
            check("f_hold_valid", 32'(s_fv), 32'd1);
            check("f_hold_pc", s_fpc, hold_pc);
         end
         if (hold_req && !s_rv) begin
            check("req_hold_valid", 32'(s_req_v), 32'd1);
            check("req_hold_addr", s_addr, hold_addr);
         end
         if (s_rv) check("req_in_redirect", 32'(s_req_v), 32'd0);
         if (s_fv && s_fr) begin
            check("f_pc_order", s_fpc, exp_pc);
            check("f_insn_data", s_insn, mem_word(s_fpc));
            if (accepted == 0) first_pc = s_fpc;
            if (s_fpc == 32'h0) saw_zero = 1'b1;
            accepted++;
            m_fetched++;
            exp_pc = exp_pc + 32'd4;
         end
         if (s_rv) begin
            exp_pc = {s_rpc[31:2], 2'b00};
            m_flush++;
         end
         if (s_req_v && s_req_rdy) hs_count++;
         if (s_req_v && !s_req_rdy) m_stall++;
         hold_f    = s_fv && !s_fr && !s_rv;
         hold_pc   = s_fpc;
         hold_req  = s_req_v && !s_req_rdy;
         hold_addr = s_addr;
      end else begin
         hold_f   = 1'b0;
         hold_req = 1'b0;
      end
      @(posedge clock);
      #1;
      if (s_rsp_v && mem_q.size() > 0) void'(mem_q.pop_front());
      if (s_reset) begin
         mem_q.delete();
      end else if (s_req_v && s_req_rdy) begin
         m.addr = s_addr;
         m.due  = cyc + lat;
         mem_q.push_back(m);
         if (mem_q.size() > DEPTH) check("outstanding_bound", mem_q.size(), DEPTH);
      end
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.f_ready        = 1'b1;
      bus.imem_req_ready = 1'b1;
      step();
      step();
      check("reset_req_valid", 32'(s_req_v), 32'd0);
      check("reset_f_valid", 32'(s_fv), 32'd0);
      check("reset_f_pc", s_fpc, 32'd0);
      check("reset_f_insn", s_insn, 32'd0);
      reset = 1'b0;
      exp_pc = PC_RESET; accepted = 0; hs_count = 0; saw_zero = 1'b0;
      m_fetched = 0; m_stall = 0; m_flush = 0;
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic check_perf();
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stall);
      check("perf_flush", perf_flush, m_flush);
   endtask
`endif

   initial begin
      // f_ready, exp_req_v, exp_req_addr, exp_fv, exp_fpc  (memory latency 1)
      tbl[0] = '{1'b1, 1'b1, 32'h0100_0000, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 1'b1, 32'h0100_0004, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0000};
      tbl[3] = '{1'b1, 1'b1, 32'h0100_0008, 1'b1, 32'h0100_0004};
      tbl[4] = '{1'b1, 1'b1, 32'h0100_000C, 1'b0, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0100_0008};
      tbl[6] = '{1'b1, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_000C};

      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      hold_f = 1'b0; hold_req = 1'b0;

      // table-driven start-up sequence
      lat = 1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         bus.f_ready = tbl[i].f_ready;
         step();
         check($sformatf("tbl%0d_req_valid", i), 32'(s_req_v), 32'(tbl[i].exp_req_v));
         if (tbl[i].exp_req_v) check($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].exp_req_addr);
         check($sformatf("tbl%0d_f_valid", i), 32'(s_fv), 32'(tbl[i].exp_fv));
         if (tbl[i].exp_fv) check($sformatf("tbl%0d_f_pc", i), s_fpc, tbl[i].exp_fpc);
      end

      // decode stalled: exactly DEPTH requests, then nothing lost on release
      do_reset();
      bus.f_ready = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("full_hs_count", hs_count, DEPTH);
      check("full_req_valid", 32'(s_req_v), 32'd0);
      bus.f_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("release_first_pc", first_pc, PC_RESET);
      check("release_progress", 32'(accepted >= 4), 32'd1);

      // redirect with two requests in flight, latency 3
      lat = 3;
      do_reset();
      step(); step();
      check("redir_inflight", hs_count, 2);
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0100_0103;
      step();
      bus.redirect_valid = 1'b0;
      accepted = 0;
      for (int i = 0; i < 15; i++) step();
      check("redir_progress", 32'(accepted > 0), 32'd1);
      check("redir_first_pc", first_pc, 32'h0100_0100);

      // redirect coinciding with a response and a decode handshake
      lat = 1;
      do_reset();
      step(); step();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0200_0010;
      step();
      check("coinc_f_valid", 32'(s_fv), 32'd1);
      check("coinc_rsp_valid", 32'(s_rsp_v), 32'd1);
      check("coinc_f_pc", s_fpc, PC_RESET);
      bus.redirect_valid = 1'b0;
      accepted = 0;
      for (int i = 0; i < 10; i++) step();
      check("coinc_progress", 32'(accepted > 0), 32'd1);
      check("coinc_first_pc", first_pc, 32'h0200_0010);

      // PC wrap through the top of the address space
      lat = 2;
      do_reset();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF9;
      step();
      bus.redirect_valid = 1'b0;
      accepted = 0;
      for (int i = 0; i < 15; i++) step();
      check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);
      check("wrap_saw_zero", 32'(saw_zero), 32'd1);

`ifdef FETCH_PERF_CNT_EN
      // 10 fetches, 4 stall cycles, 1 redirect
      lat = 1;
      do_reset();
      bus.imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      bus.imem_req_ready = 1'b1;
      for (int i = 0; i < 200 && accepted < 10; i++) step();
      bus.f_ready = 1'b0;
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0300_0000;
      step();
      bus.redirect_valid = 1'b0;
      step();
      check("perf_fetched_10", perf_fetched, 32'd10);
      check("perf_stall_4", perf_stall, 32'd4);
      check("perf_flush_1", perf_flush, 32'd1);
`endif

      // randomized traffic against the stream model, with a mid-run reset
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < 1500; i++) begin
            lat = $urandom_range(1, 4);
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.f_ready        = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 29) == 0);
            bus.redirect_pc    = $urandom;
            step();
         end
         bus.redirect_valid = 1'b0;
         check($sformatf("rand%0d_progress", pass), 32'(accepted > 100), 32'd1);
`ifdef FETCH_PERF_CNT_EN
         check_perf();
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end for the pipelined core: owns the PC, issues word reads to instruction memory, and pairs each returned word with its PC.
- Presents fetched instructions to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from downstream.
- Sits between the clock/reset wrapper, the instruction memory and decode inside the core.

Parameters:
- PC_RESET, 32'h0100_0000, first fetch address after reset.
- AWIDTH, 32, address/PC width.
- DWIDTH, 32, instruction width.
- DEPTH, 2, maximum outstanding requests plus buffered instructions (power of 2, >=2).

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  AWIDTH  word-aligned read address.
- imem_rsp_valid  in  1  read data valid; responses return in order, latency >=1 cycle.
- imem_rsp_data  in  DWIDTH  read data.
- redirect_valid  in  1  redirect PC this cycle.
- redirect_pc  in  AWIDTH  new fetch target.
- f_valid  out  1  instruction available to decode.
- f_ready  in  1  decode accepts this cycle.
- f_pc  out  AWIDTH  PC of presented instruction.
- f_insn  out  DWIDTH  presented instruction.

Behaviour:
- Reset: one clock, reset is synchronous and active-high. On reset, pc=PC_RESET, outstanding=0, drop=0, buffer empty. imem_req_valid=0, f_valid=0, f_pc=0, f_insn=0 while reset is high.
- First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=PC_RESET.
- Issue rule: imem_req_valid = !reset && !redirect_valid && (outstanding + drop + occupancy < DEPTH).
  - A request handshake occurs when imem_req_valid && imem_req_ready.
  - On handshake: push pc into the in-flight tag queue, pc += 4, outstanding += 1.
  - imem_req_addr = pc, held stable while valid and not ready.
- Response (imem_rsp_valid):
  - If drop>0: discard the response, drop -= 1.
  - Else: pop the tag, write {tag, data} into the output buffer, outstanding -= 1.
  - A response never arrives with outstanding+drop==0; the bench flags this as an error.
- Output: f_valid = buffer non-empty; f_pc/f_insn = buffer head, stable until f_ready.
  - Pop on f_valid && f_ready.
  - No combinational path from imem_rsp_* to f_*: minimum request-to-f_valid latency is mem latency + 1.
- Redirect (redirect_valid=1):
  - Next pc = {redirect_pc[AWIDTH-1:2], 2'b00}.
  - Buffer and tag queue are flushed.
  - drop += outstanding, outstanding = 0.
  - A response arriving in the same cycle is discarded and counts against the pre-redirect outstanding.
  - A decode handshake in the same cycle completes normally; remaining entries are flushed.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; drop accumulates and never exceeds DEPTH.
- Full: when outstanding+drop+occupancy==DEPTH, requests stall; f_ready=0 indefinitely must not lose data.
- Wrap: pc increments modulo 2^AWIDTH (32'hFFFF_FFFC -> 0).
- Reset mid-operation: all counters and queues clear; late memory responses after reset are ignored only via the drop mechanism if the wrapper guarantees none arrive; memory is also reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds outputs perf_fetched (32b, +1 per decode handshake), perf_stall (32b, +1 per cycle with imem_req_valid && !imem_req_ready) and perf_flush (32b, +1 per redirect cycle). All clear on reset and saturate at all-ones.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pd_pkg: PC_RESET, INSN_NOP=32'h0000_0013, addr_t/insn_t typedefs, fetch_entry_t {pc, insn}.
- One sub-module fetch_fifo: parameterised sync FIFO (push/pop/flush, count, full/empty), instantiated twice (tag queue, output buffer).

Test Plan:
- Reset then memory with 1-cycle latency, f_ready=1 -> f_pc sequence 01000000, 01000004, 01000008... with correct data, first f_valid 3 cycles after reset falls.
- f_ready=0 for 20 cycles -> exactly DEPTH requests issued, then imem_req_valid=0; on release, entries come out in order with none lost.
- Memory latency 3, redirect to 32'h0100_0103 with 2 in flight -> both stale responses dropped, next f_pc=0100_0100.
- Redirect coinciding with a response and a decode handshake -> handshake completes, response discarded, following f_pc=redirect target.
- PC_RESET=32'hFFFF_FFF8 -> f_pc FFFFFFF8, FFFFFFFC, 00000000.
- With FETCH_PERF_CNT_EN: 10 fetches, 4 stall cycles, 1 redirect -> counters read 10/4/1.
